// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage next-PC predictor.
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookup is combinational from F_pc; training happens on EX branch resolution.
// Optional build macro: BP_STATS_EN adds resolved-branch and mispredict counters.
module branch_predictor #(
  parameter int XLEN       = 5,
  parameter int INDEX_BITS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] F_pc,
  output logic            F_BP_taken,
  output logic [XLEN-1:0] F_BP_target_pc,
  input  logic            EX_br_valid,
  input  logic [XLEN-1:0] EX_br_pc,
  input  logic            EX_br_taken,
`ifdef BP_STATS_EN
  input  logic            EX_br_mispredict,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispredicts,
`endif
  input  logic [XLEN-1:0] EX_br_target
);

  localparam int TAG_BITS = XLEN - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  // BTB storage, one slot per index.
  logic                r_valid  [ENTRIES];
  logic [TAG_BITS-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0]     r_target [ENTRIES];
  logic [1:0]          r_ctr    [ENTRIES];

  // Lookup side (fetch PC).
  logic [INDEX_BITS-1:0] w_rd_idx;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic                  w_rd_hit;
  logic [XLEN-1:0]       w_seq_pc;

  // Update side (resolved branch PC).
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [TAG_BITS-1:0]   w_wr_tag;
  logic                  w_wr_hit;
  logic [1:0]            w_ctr_inc;
  logic [1:0]            w_ctr_dec;

  assign w_rd_idx = F_pc[INDEX_BITS-1:0];
  assign w_rd_tag = F_pc[XLEN-1:INDEX_BITS];
  assign w_seq_pc = F_pc + XLEN'(1);

  assign w_wr_idx = EX_br_pc[INDEX_BITS-1:0];
  assign w_wr_tag = EX_br_pc[XLEN-1:INDEX_BITS];

  // Lookup reads the registered array only, so a same-cycle update to the
  // same index is seen by fetch on the following cycle (no bypass).
  always_comb begin
    w_rd_hit       = 1'b0;
    F_BP_taken     = 1'b0;
    F_BP_target_pc = w_seq_pc;
    w_rd_hit       = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
    F_BP_taken     = !rst && w_rd_hit && r_ctr[w_rd_idx][1];
    if (F_BP_taken) begin
      F_BP_target_pc = r_target[w_rd_idx];
    end
  end

  // Saturating next values for the entry addressed by the resolving branch.
  always_comb begin
    w_wr_hit  = r_valid[w_wr_idx] && (r_tag[w_wr_idx] == w_wr_tag);
    w_ctr_inc = (r_ctr[w_wr_idx] == 2'b11) ? 2'b11 : r_ctr[w_wr_idx] + 2'b01;
    w_ctr_dec = (r_ctr[w_wr_idx] == 2'b00) ? 2'b00 : r_ctr[w_wr_idx] - 2'b01;
  end

  // Update port: valid-only, no ready. EX_br_valid high for one cycle means
  // one resolved branch described by EX_br_pc/taken/target is consumed at
  // that clock edge; when it is low every other EX_br_* input is ignored.
  // Training: hits move the counter, taken misses allocate weakly-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
    end else if (EX_br_valid) begin
      if (w_wr_hit) begin
        if (EX_br_taken) begin
          r_ctr[w_wr_idx]    <= w_ctr_inc;
          r_target[w_wr_idx] <= EX_br_target;
        end else begin
          r_ctr[w_wr_idx] <= w_ctr_dec;
        end
      end else if (EX_br_taken) begin
        r_valid[w_wr_idx]  <= 1'b1;
        r_tag[w_wr_idx]    <= w_wr_tag;
        r_target[w_wr_idx] <= EX_br_target;
        r_ctr[w_wr_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_mispredicts;

  // Saturating event counters for resolutions and mispredicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (EX_br_valid) begin
      if (r_stat_branches != 16'hFFFF) begin
        r_stat_branches <= r_stat_branches + 16'd1;
      end
      if (EX_br_mispredict && (r_stat_mispredicts != 16'hFFFF)) begin
        r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
      end
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed training sequences with literal
// expectations, plus a per-cycle compare against a behavioural BTB model.
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int XLEN       = 5;
  localparam int INDEX_BITS = 3;
  localparam int ENTRIES    = 8;
  localparam int PC_MOD     = 32;

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [XLEN-1:0] F_pc;
  logic            F_BP_taken;
  logic [XLEN-1:0] F_BP_target_pc;
  logic            EX_br_valid;
  logic [XLEN-1:0] EX_br_pc;
  logic            EX_br_taken;
  logic [XLEN-1:0] EX_br_target;
  logic            EX_br_mispredict;
`ifdef BP_STATS_EN
  logic [15:0]     stat_branches;
  logic [15:0]     stat_mispredicts;
`endif

  branch_predictor #(.XLEN(XLEN), .INDEX_BITS(INDEX_BITS)) dut (
    .clk             (clk),
    .rst             (rst),
    .F_pc            (F_pc),
    .F_BP_taken      (F_BP_taken),
    .F_BP_target_pc  (F_BP_target_pc),
    .EX_br_valid     (EX_br_valid),
    .EX_br_pc        (EX_br_pc),
    .EX_br_taken     (EX_br_taken),
`ifdef BP_STATS_EN
    .EX_br_mispredict(EX_br_mispredict),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts),
`endif
    .EX_br_target    (EX_br_target)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Behavioural model: each slot remembers the full PC that owns it and a
  // confidence level 0..3; the slot for a PC is pc mod ENTRIES.
  bit m_valid [ENTRIES];
  int m_owner [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_str   [ENTRIES];
  int m_branches;
  int m_mispredicts;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_owner[i] = 0; m_tgt[i] = 0; m_str[i] = 1;
    end
    m_branches = 0; m_mispredicts = 0;
  endfunction

  function automatic bit model_taken(input int pc);
    int s = pc % ENTRIES;
    return m_valid[s] && (m_owner[s] == pc) && (m_str[s] >= 2);
  endfunction

  function automatic int model_next(input int pc);
    int s = pc % ENTRIES;
    if (model_taken(pc)) return m_tgt[s];
    return (pc + 1) % PC_MOD;
  endfunction

  function automatic void model_update(input int pc, input bit tk, input int tgt, input bit mis);
    int s = pc % ENTRIES;
    if (m_valid[s] && m_owner[s] == pc) begin
      if (tk) begin
        m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
        m_tgt[s] = tgt;
      end else begin
        m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[s] = 1; m_owner[s] = pc; m_tgt[s] = tgt; m_str[s] = 2;
    end
    if (m_branches < 65535) m_branches++;
    if (mis && m_mispredicts < 65535) m_mispredicts++;
  endfunction

  initial model_reset();

  // Model training at the clock edge, from inputs settled since the last edge.
  always @(posedge clk) begin
    if (!rst && EX_br_valid)
      model_update(EX_br_pc, EX_br_taken, EX_br_target, EX_br_mispredict);
  end

  // Scoreboard compare on the falling edge, every cycle.
  always @(negedge clk) begin
    if (rst) model_reset();
    check("cmp_taken", F_BP_taken, model_taken(F_pc));
    check("cmp_target", F_BP_target_pc, model_next(F_pc));
`ifdef BP_STATS_EN
    check("cmp_stat_branches", stat_branches, m_branches);
    check("cmp_stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int pc, input bit tk, input int tgt, input bit mis);
    EX_br_valid      = 1'b1;
    EX_br_pc         = pc[XLEN-1:0];
    EX_br_taken      = tk;
    EX_br_target     = tgt[XLEN-1:0];
    EX_br_mispredict = mis;
    cycle();
    EX_br_valid      = 1'b0;
    EX_br_mispredict = 1'b0;
  endtask

  task automatic look(input int pc, input bit exp_tk, input int exp_tgt, input string name);
    F_pc = pc[XLEN-1:0];
    #1;
    check({name, "_taken"}, F_BP_taken, exp_tk);
    check({name, "_target"}, F_BP_target_pc, exp_tgt);
    cycle();
  endtask

  // Watchdog
  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    rst = 1'b1; F_pc = 5'd3;
    EX_br_valid = 0; EX_br_pc = 0; EX_br_taken = 0; EX_br_target = 0; EX_br_mispredict = 0;
    #2;
    check("rst_pc3_taken", F_BP_taken, 0);
    check("rst_pc3_target", F_BP_target_pc, 4);
    cycle(); cycle();
    rst = 1'b0;
    look(31, 0, 0, "wrap31");

    // Train pc=10 then reset mid-update: entry must be gone.
    upd(10, 1, 2, 0);
    look(10, 1, 2, "pre_rst_10");
    F_pc = 5'd10;
    EX_br_valid = 1; EX_br_pc = 5'd10; EX_br_taken = 1; EX_br_target = 5'd9;
    #2; rst = 1'b1; #1;
    check("in_rst_10_taken", F_BP_taken, 0);
    check("in_rst_10_target", F_BP_target_pc, 11);
    cycle();
    EX_br_valid = 0;
    cycle();
    rst = 1'b0;
    look(10, 0, 11, "post_rst_10");

    // Allocate and alias check.
    upd(10, 1, 2, 0);
    look(10, 1, 2, "alloc_10");
    look(18, 0, 19, "alias_18");

    // Counter training on pc=10 (starts weakly taken).
    upd(10, 0, 0, 0);  look(10, 0, 11, "ctr01");
    upd(10, 1, 2, 0);  look(10, 1, 2, "ctr10");
    upd(10, 1, 2, 0); upd(10, 1, 2, 0); upd(10, 1, 2, 0);
    look(10, 1, 2, "ctr11");
    upd(10, 0, 0, 0);  look(10, 1, 2, "ctr11_to_10");
    upd(10, 0, 0, 0);  look(10, 0, 11, "ctr10_to_01");
    upd(10, 0, 0, 0); upd(10, 0, 0, 0); upd(10, 0, 0, 0);
    upd(10, 1, 2, 0);  look(10, 0, 11, "ctr00_floor");
    upd(10, 1, 2, 0);  look(10, 1, 2, "ctr_retrain");

    // Not-taken miss does not allocate; taken alias evicts.
    upd(7, 0, 3, 0);   look(7, 0, 8, "nt_miss_7");
    upd(18, 1, 5, 0);
    look(10, 0, 11, "evicted_10");
    look(18, 1, 5, "new_18");

    // Same-cycle lookup/update hazard.
    upd(10, 1, 2, 0);
    F_pc = 5'd10;
    EX_br_valid = 1; EX_br_pc = 5'd10; EX_br_taken = 1; EX_br_target = 5'd6;
    #1;
    check("hazard_same_taken", F_BP_taken, 1);
    check("hazard_same_target", F_BP_target_pc, 2);
    cycle();
    EX_br_valid = 0;
    #1;
    check("hazard_next_target", F_BP_target_pc, 6);

    // Inputs with EX_br_valid low are ignored.
    EX_br_pc = 5'd10; EX_br_taken = 1; EX_br_target = 5'd9;
    cycle();
    look(10, 1, 6, "valid_low_ignored");

    // Top-of-range PC entry.
    upd(31, 1, 17, 0);
    look(31, 1, 17, "entry31");

    // Randomised traffic checked only by the model.
    for (int i = 0; i < 200; i++) begin
      F_pc             = 5'($urandom_range(0, 31));
      EX_br_valid      = ($urandom_range(0, 3) != 0);
      EX_br_pc         = 5'($urandom_range(0, 31));
      EX_br_taken      = $urandom_range(0, 1) != 0;
      EX_br_target     = 5'($urandom_range(0, 31));
      EX_br_mispredict = $urandom_range(0, 1) != 0;
      cycle();
    end
    EX_br_valid = 0; EX_br_mispredict = 0;

`ifdef BP_STATS_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    upd(10, 1, 2, 1); upd(10, 0, 0, 0); upd(3, 1, 4, 1); upd(4, 0, 0, 0); upd(10, 1, 2, 0);
    check("stat_branches_5", stat_branches, 5);
    check("stat_mispredicts_2", stat_mispredicts, 2);
    EX_br_valid = 1; EX_br_pc = 5'd7; EX_br_taken = 0; EX_br_mispredict = 0;
    repeat (65535) @(posedge clk);
    #1;
    EX_br_valid = 0;
    check("stat_branches_sat", stat_branches, 16'hFFFF);
    check("stat_mispredicts_hold", stat_mispredicts, 2);
    cycle();
`endif

    cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
